// File: rtl/input_debouncer_pkg.sv
// rtl/input_debouncer_pkg.sv - channel count, default timing constants and channel state encoding
package input_debouncer_pkg;

  localparam int NUM_CH              = 3;
  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_CNT_WIDTH       = 16;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } ch_state_e;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one-bit synchronizer, debounce counter/FSM and optional edge pulses
// Edge pulses are built only when INPUT_DEBOUNCER_EDGE_EN is defined.
module debounce_channel
  import input_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_clean,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [CNT_WIDTH-1:0] TERM_CNT = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ONE_CNT  = CNT_WIDTH'(1);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_clean;
  ch_state_e            r_state;
  ch_state_e            w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 w_toggle;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_clean <= 1'b0;
      r_state <= ST_STABLE;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_clean <= r_clean ^ w_toggle;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_toggle    = 1'b0;
    case (r_state)
      ST_STABLE: begin
        w_cnt_nxt = '0;
        if (r_sync2 != r_clean) begin
          // A one-cycle debounce window toggles straight from STABLE.
          if (DEBOUNCE_CYCLES == 1) begin
            w_toggle = 1'b1;
          end else begin
            w_state_nxt = ST_COUNTING;
            w_cnt_nxt   = ONE_CNT;
          end
        end
      end
      ST_COUNTING: begin
        if (r_sync2 == r_clean) begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TERM_CNT) begin
          w_toggle    = 1'b1;
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + ONE_CNT;
        end
      end
      default: begin
        w_state_nxt = ST_STABLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_clean = r_clean;

`ifdef INPUT_DEBOUNCER_EDGE_EN
  logic r_rise;
  logic r_fall;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_toggle & ~r_clean;
      r_fall <= w_toggle & r_clean;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;
`else
  assign o_rise = 1'b0;
  assign o_fall = 1'b0;
`endif

endmodule

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - three independent debounced channels feeding the OR-gate inputs
// risePulse/fallPulse are live only when INPUT_DEBOUNCER_EDGE_EN is defined, else tied low.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] rawIn,
  output logic [NUM_CH-1:0] cleanOut,
  output logic [NUM_CH-1:0] risePulse,
  output logic [NUM_CH-1:0] fallPulse
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
    ) u_ch (
      .i_clk  (clk),
      .i_reset(reset),
      .i_raw  (rawIn[k]),
      .o_clean(cleanOut[k]),
      .o_rise (risePulse[k]),
      .o_fall (fallPulse[k])
    );
  end

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - directed bench with a mismatch-run model and hand-computed checkpoints
module tb_input_debouncer;

  localparam int D = 4;
  localparam int W = 4;
`ifdef INPUT_DEBOUNCER_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] rawIn = 3'b000;
  logic [2:0] cleanOut;
  logic [2:0] risePulse;
  logic [2:0] fallPulse;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  input_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .CNT_WIDTH      (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rawIn    (rawIn),
    .cleanOut (cleanOut),
    .risePulse(risePulse),
    .fallPulse(fallPulse)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] pexp(input logic [2:0] v);
    return EDGE_EN ? v : 3'b000;
  endfunction

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: sync2 is rawIn two edges late; cleanOut flips once sync2 has
  // disagreed with it on D consecutive edges.
  logic [2:0] m_clean = 3'b000;
  logic [2:0] m_rise = 3'b000;
  logic [2:0] m_fall = 3'b000;
  logic [2:0] m_s1 = 3'b000;
  logic [2:0] m_s2 = 3'b000;
  int         m_run[3];

  initial begin
    for (int k = 0; k < 3; k++) m_run[k] = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_clean = 3'b000;
        m_rise  = 3'b000;
        m_fall  = 3'b000;
        m_s1    = 3'b000;
        m_s2    = 3'b000;
        for (int k = 0; k < 3; k++) m_run[k] = 0;
      end else begin
        m_rise = 3'b000;
        m_fall = 3'b000;
        for (int k = 0; k < 3; k++) begin
          m_run[k] = (m_s2[k] != m_clean[k]) ? m_run[k] + 1 : 0;
          if (m_run[k] == D) begin
            m_run[k]   = 0;
            m_rise[k]  = EDGE_EN & ~m_clean[k];
            m_fall[k]  = EDGE_EN & m_clean[k];
            m_clean[k] = ~m_clean[k];
          end
        end
        m_s2 = m_s1;
        m_s1 = rawIn;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("model_clean", cleanOut, m_clean);
        chk("model_rise", risePulse, m_rise);
        chk("model_fall", fallPulse, m_fall);
      end
    end
  end

  logic [2:0] vec_val[9] = '{3'b101, 3'b010, 3'b111, 3'b000, 3'b110, 3'b011, 3'b100, 3'b001, 3'b000};
  int         vec_len[9] = '{2, 5, 1, 4, 7, 3, 6, 4, 10};

  initial begin
    #2 reset = 1'b1;
    started = 1'b1;
    #1;
    chk("por_clean", cleanOut, 3'b000);
    chk("por_rise", risePulse, 3'b000);
    chk("por_fall", fallPulse, 3'b000);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;

    // Clean step on channel 0
    tick(1);
    rawIn = 3'b001;
    tick(5);
    chk("step_early", cleanOut, 3'b000);
    tick(1);
    chk("step_clean", cleanOut, 3'b001);
    chk("step_rise", risePulse, pexp(3'b001));
    tick(1);
    chk("step_rise_end", risePulse, 3'b000);
    chk("step_hold", cleanOut, 3'b001);

    // Glitch of D-1 cycles rejected, D cycles accepted, then minimum spacing fall
    rawIn = 3'b011;
    tick(3);
    rawIn = 3'b001;
    tick(8);
    chk("glitch_reject", cleanOut, 3'b001);
    rawIn = 3'b011;
    tick(4);
    rawIn = 3'b001;
    tick(1);
    chk("glitch_pre", cleanOut, 3'b001);
    tick(1);
    chk("glitch_pass", cleanOut, 3'b011);
    chk("glitch_rise", risePulse, pexp(3'b010));
    tick(3);
    chk("spacing_hold", cleanOut, 3'b011);
    tick(1);
    chk("spacing_fall", cleanOut, 3'b001);
    chk("spacing_fpulse", fallPulse, pexp(3'b010));

    // All high, then all low in one cycle
    rawIn = 3'b111;
    tick(8);
    chk("all_high", cleanOut, 3'b111);
    rawIn = 3'b000;
    tick(5);
    chk("fall_early", cleanOut, 3'b111);
    tick(1);
    chk("fall_all", cleanOut, 3'b000);
    chk("fall_pulse", fallPulse, pexp(3'b111));
    chk("fall_norise", risePulse, 3'b000);
    tick(1);
    chk("fall_pulse_end", fallPulse, 3'b000);

    // Reset in the middle of a count on channel 2
    rawIn = 3'b100;
    tick(4);
    #2 reset = 1'b1;
    #1;
    chk("midcnt_reset", cleanOut, 3'b000);
    @(posedge clk);
    #3 reset = 1'b0;
    tick(5);
    chk("midcnt_early", cleanOut, 3'b000);
    tick(1);
    chk("midcnt_clean", cleanOut, 3'b100);
    chk("midcnt_rise", risePulse, pexp(3'b100));

    // Async reset with all inputs high, then full latency after release
    rawIn = 3'b111;
    tick(8);
    chk("pre_reset_high", cleanOut, 3'b111);
    #2 reset = 1'b1;
    #1;
    chk("async_clean", cleanOut, 3'b000);
    chk("async_rise", risePulse, 3'b000);
    chk("async_fall", fallPulse, 3'b000);
    @(posedge clk);
    #3 reset = 1'b0;
    tick(5);
    chk("rel_early", cleanOut, 3'b000);
    chk("rel_nopulse", risePulse, 3'b000);
    tick(1);
    chk("rel_clean", cleanOut, 3'b111);
    chk("rel_rise", risePulse, pexp(3'b111));
    tick(1);
    chk("rel_rise_end", risePulse, 3'b000);

    // Mixed directed vectors, checked by the model every cycle
    for (int i = 0; i < 9; i++) begin
      rawIn = vec_val[i];
      tick(vec_len[i]);
    end
    tick(10);
    chk("final_clean", cleanOut, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Three-channel input conditioner that sits directly upstream of the three-input OR gate. It takes raw, asynchronous switch/pushbutton levels and synchronizes each one to `clk`, then debounces it. The resulting stable levels drive the gate inputs `i1`, `i2` and `i3` (`cleanOut[0..2]`). Optional single-cycle edge pulses let later stages count or latch events without doing their own edge detection.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive cycles a synchronized input must differ from `cleanOut` before `cleanOut` follows it. Legal range is 1 to 2^CNT_WIDTH−1.
- `CNT_WIDTH`, default 16: width of each per-channel counter.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset. It clears all state immediately.
- `rawIn`  in  3  raw asynchronous levels. Bit k feeds channel k.
- `cleanOut`  out  3  debounced levels. Bit 0 drives `i1`, bit 1 drives `i2`, bit 2 drives `i3`.
- `risePulse`  out  3  one-cycle pulse per channel when `cleanOut[k]` goes 0→1.
- `fallPulse`  out  3  one-cycle pulse per channel when `cleanOut[k]` goes 1→0.

## Operation
- Each channel is independent and identical. There is no cross-channel interaction.
- **Synchronizer:** two flops, `rawIn[k]` → `sync1` → `sync2`.
- **Per-channel FSM:**
  - STABLE: `sync2 == cleanOut[k]`. Counter is held at 0. Move to COUNTING when `sync2 != cleanOut[k]`; the counter becomes 1 on that edge when DEBOUNCE_CYCLES>1.
  - COUNTING: the counter increments each edge while `sync2 != cleanOut[k]`.
    - If `sync2` returns to equal `cleanOut[k]` before the terminal count, the counter clears to 0 and the FSM returns to STABLE. This is glitch rejection.
    - At an edge where the mismatch persists and counter == DEBOUNCE_CYCLES−1, `cleanOut[k]` toggles, the counter clears and the FSM returns to STABLE.
- **DEBOUNCE_CYCLES=1:** `cleanOut` follows `sync2` with one cycle of delay, and COUNTING is never held.
- **Counter arithmetic:** unsigned, CNT_WIDTH bits. The counter never wraps, because the terminal compare fires first.
- **Simultaneous changes:** events on several channels in the same cycle are all handled independently in that same cycle.
- **Edge pulses:** `risePulse[k]` / `fallPulse[k]` are registered. Each is high for exactly one cycle, beginning on the same edge where `cleanOut[k]` toggles. They are never both high together.

## Timing
- **Reset values:** `cleanOut`=3'b000, `risePulse`=3'b000, `fallPulse`=3'b000. Sync flops=0, counters=0, all FSMs in STABLE.
- **Reset mid-count:** counting is abandoned. After release, a `rawIn` held at 1 requires the full latency again. No pulse is generated by reset itself.
- **Latency:** `rawIn[k]` changes and is stable before rising edge E0. Then `sync1` updates at E0 and `sync2` at E0+1, and `cleanOut[k]` plus the pulse update at E0+DEBOUNCE_CYCLES+1.
- **Glitch rejection:** a `rawIn` pulse shorter than DEBOUNCE_CYCLES cycles (as seen at `sync2`) never reaches `cleanOut`.
- **Throughput:** the minimum spacing between successive `cleanOut` toggles on one channel is DEBOUNCE_CYCLES cycles.

## Configuration
- `INPUT_DEBOUNCER_EDGE_EN`
  - Defined: pulse registers and edge logic are built, and `risePulse`/`fallPulse` behave as above.
  - Undefined: no pulse logic is synthesized, and `risePulse`/`fallPulse` are tied to 3'b000. Ports remain present so the instantiating level is unchanged.
  - `cleanOut` behaviour is identical in both builds.

## Structure
- **Package `input_debouncer_pkg`:** `NUM_CH`=3, the default `DEBOUNCE_CYCLES`/`CNT_WIDTH` constants, and the channel state encoding (STABLE=0, COUNTING=1).
- **Sub-module `debounce_channel`:** synchronizer, counter, FSM and optional edge pulse for one bit. It is instantiated NUM_CH times via generate. The top level does only wiring.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and CNT_WIDTH=4.

- **Reset:** assert `reset` with `rawIn`=3'b111, async, mid-cycle → all outputs 0 immediately. Release → `cleanOut`=3'b111 at release-edge+5; `risePulse`=3'b111 for exactly that one cycle.
- **Clean step:** `rawIn[0]` 0→1 before edge E0 → `cleanOut[0]`=1 at E0+5 and `risePulse[0]`=1 for one cycle. `cleanOut[2:1]` stay 0.
- **Glitch:** `rawIn[1]` high for 3 cycles, then low → `cleanOut[1]` stays 0; no pulses. Then 4 cycles high → `cleanOut[1]` rises.
- **Fall and simultaneity:** all channels at 1, then `rawIn`=3'b000 in one cycle → `cleanOut`=3'b000 on the same edge and `fallPulse`=3'b111 for one cycle.
- **Reset mid-count:** `rawIn[2]`=1 and reset pulsed at E0+3 → `cleanOut[2]` stays 0 until release+5.
- **Macro off:** rerun the clean-step case without `INPUT_DEBOUNCER_EDGE_EN` → identical `cleanOut` timing; `risePulse`/`fallPulse` stay 3'b000 throughout.
